// File: rtl/integral_image_writer.sv
// rtl/integral_image_writer.sv - streaming integral-image generator with a one-row line buffer
module integral_image_writer #(
    parameter int IMG_WIDTH  = 20,
    parameter int IMG_HEIGHT = 20,
    parameter int PIX_W      = 8,
    parameter int SUM_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             ii_we,
    output logic [7:0]       ii_x,
    output logic [7:0]       ii_y,
    output logic [SUM_W-1:0] ii_wdata,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         XW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int         SW1    = SUM_W + 1;
    localparam logic [7:0] X_LAST = 8'(IMG_WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(IMG_HEIGHT - 1);

    logic [1:0]       state;
    logic [7:0]       x_cnt;
    logic [7:0]       y_cnt;
    logic [SUM_W-1:0] row_sum;
    logic [SUM_W-1:0] line_buf [IMG_WIDTH];

    logic             accept;
    logic             last_pix;
    logic [XW-1:0]    x_idx;
    logic [SUM_W-1:0] row_base;
    logic [SUM_W-1:0] above;
    logic [SUM_W:0]   row_ext;
    logic [SUM_W:0]   ii_ext;
    logic             carry;

    assign pix_ready  = (state == S_RUN);
    assign busy       = (state == S_RUN) || (state == S_FLUSH);
    assign frame_done = (state == S_DONE);
    assign accept     = pix_valid & pix_ready;
    assign last_pix   = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    assign x_idx      = x_cnt[XW-1:0];

    // The extra MSB of each sum is the carry out of SUM_W bits.
    always_comb begin
        row_base = (x_cnt == '0) ? '0 : row_sum;
        above    = (y_cnt == '0) ? '0 : line_buf[x_idx];
        row_ext  = {1'b0, row_base} + SW1'(pix_data);
        ii_ext   = {1'b0, above} + {1'b0, row_ext[SUM_W-1:0]};
        carry    = row_ext[SUM_W] | ii_ext[SUM_W];
    end

    // Line buffer has no reset: row 0 never reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[x_idx] <= ii_ext[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            row_sum  <= '0;
            overflow <= 1'b0;
            ii_we    <= 1'b0;
            ii_x     <= '0;
            ii_y     <= '0;
            ii_wdata <= '0;
        end else begin
            ii_we <= accept;
            if (accept) begin
                ii_x     <= x_cnt;
                ii_y     <= y_cnt;
                ii_wdata <= ii_ext[SUM_W-1:0];
                row_sum  <= row_ext[SUM_W-1:0];
                if (carry) begin
                    overflow <= 1'b1;
                end
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 8'd1;
                end else begin
                    x_cnt <= x_cnt + 8'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        row_sum  <= '0;
                        overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (accept && last_pix) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_integral_image_writer.sv
// tb/tb_integral_image_writer.sv - directed self-checking bench for integral_image_writer
module tb_integral_image_writer;
    localparam int W = 20;
    localparam int H = 20;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        ii_we;
    logic [7:0]  ii_x;
    logic [7:0]  ii_y;
    logic [15:0] ii_wdata;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    int          cmp_n = 0;
    int          err_n = 0;
    int          model [H][W];
    logic [15:0] got   [H][W];

    integral_image_writer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (8),
        .SUM_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .ii_we     (ii_we),
        .ii_x      (ii_x),
        .ii_y      (ii_y),
        .ii_wdata  (ii_wdata),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix_of(input int pat, input int x, input int y);
        case (pat)
            0:       return 1;
            1:       return x + y;
            default: return 255;
        endcase
    endfunction

    // Unbounded integer sums; the DUT output is these taken mod 2^16.
    task automatic build_model(input int pat);
        int rs;
        for (int y = 0; y < H; y++) begin
            rs = 0;
            for (int x = 0; x < W; x++) begin
                rs = rs + pix_of(pat, x, y);
                model[y][x] = ((y == 0) ? 0 : model[y-1][x]) + rs;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"},  pix_ready,  0);
        check({tag, "_ii_we"},      ii_we,      0);
        check({tag, "_ii_x"},       ii_x,       0);
        check({tag, "_ii_y"},       ii_y,       0);
        check({tag, "_ii_wdata"},   ii_wdata,   0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overflow"},   overflow,   0);
    endtask

    task automatic run_frame(input int pat, input bit gappy, input int restart_at);
        int          idx;
        int          cyc;
        int          x;
        int          y;
        bit          v;
        bit          ovf_exp;
        logic [7:0]  lx;
        logic [7:0]  ly;
        logic [15:0] lw;
        build_model(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy",     busy,      1);
        check("start_ready",    pix_ready, 1);
        check("start_overflow", overflow,  0);
        check("start_ii_we",    ii_we,     0);
        idx = 0; cyc = 0; ovf_exp = 1'b0;
        lx = '0; ly = '0; lw = '0;
        while (idx < N && cyc < 4 * N) begin
            x = idx % W;
            y = idx / W;
            v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid = v;
            pix_data  = 8'(pix_of(pat, x, y));
            start     = (idx == restart_at);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            check("ii_we", ii_we, 32'(v));
            if (v) begin
                if (model[y][x] > 65535) ovf_exp = 1'b1;
                check("ii_x",     ii_x,     x);
                check("ii_y",     ii_y,     y);
                check("ii_wdata", ii_wdata, model[y][x] & 32'hFFFF);
                check("overflow", overflow, 32'(ovf_exp));
                got[y][x] = ii_wdata;
                lx = ii_x; ly = ii_y; lw = ii_wdata;
                idx++;
            end else if (idx > 0) begin
                check("hold_x",     ii_x,     lx);
                check("hold_y",     ii_y,     ly);
                check("hold_wdata", ii_wdata, lw);
            end
            check("run_frame_done", frame_done, 0);
            check("run_busy",       busy,       1);
            check("run_ready",      pix_ready,  (idx < N) ? 1 : 0);
        end
        if (idx < N) check("frame_timeout", idx, N);
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("done_pulse",    frame_done, 1);
        check("done_busy",     busy,       0);
        check("done_ii_we",    ii_we,      0);
        check("done_ready",    pix_ready,  0);
        check("done_overflow", overflow,   32'(ovf_exp));
        @(posedge clk); #1;
        check("done_end",      frame_done, 0);
        check("idle_ovf_held", overflow,   32'(ovf_exp));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", pix_ready, 0);
        check("idle_busy",  busy,      0);

        // All-ones frame: ii(x,y) = (x+1)(y+1).
        run_frame(0, 1'b0, -1);
        check("ones_19_19", got[19][19], 400);
        check("ones_0_0",   got[0][0],   1);
        check("ones_2_4",   got[4][2],   15);

        // Pixel = x + y.
        run_frame(1, 1'b0, -1);
        check("xy_0_0", got[0][0], 0);
        check("xy_1_0", got[0][1], 1);
        check("xy_1_1", got[1][1], 4);

        // Saturated pixels wrap mod 2^16 and raise the sticky flag.
        run_frame(2, 1'b0, -1);
        check("sat_19_19", got[19][19], 36464);

        // Random valid gaps.
        run_frame(0, 1'b1, -1);
        check("gap_19_19", got[19][19], 400);

        // Reset in the middle of row 5 abandons the frame.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pix_valid = 1'b1; pix_data = 8'd1;
        repeat (5 * W + 7) @(posedge clk);
        #1;
        check("pre_reset_we", ii_we, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check_reset_outputs("midrst_hold");
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", busy, 0);
        run_frame(0, 1'b0, -1);
        check("rst_ones_19_19", got[19][19], 400);

        // Second start while running must be ignored.
        run_frame(0, 1'b0, 150);
        check("restart_19_19", got[19][19], 400);
        repeat (3) begin
            @(posedge clk); #1;
            check("restart_no_2nd_done", frame_done, 0);
            check("restart_idle_busy",   busy,       0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule

// File: doc/integral_image_writer.md
INTEGRAL_IMAGE_WRITER -- requirements
Module: integral_image_writer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 20, meaning pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 20, meaning rows per frame.
REQ-003 SHALL have parameter PIX_W, default 8, meaning pixel width in bits, unsigned.
REQ-004 SHALL have parameter SUM_W, default 16, meaning integral-image word width in bits, unsigned.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that arms capture of one frame.
REQ-008 SHALL have port pix_valid  input  1  pix_data holds a valid pixel.
REQ-009 SHALL have port pix_data  input  PIX_W  pixel value, raster order (x fastest, then y).
REQ-010 SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 SHALL have port ii_we  output  1  integral-image write strobe.
REQ-012 SHALL have port ii_x  output  8  write column index.
REQ-013 SHALL have port ii_y  output  8  write row index.
REQ-014 SHALL have port ii_wdata  output  SUM_W  integral-image value for (ii_x, ii_y).
REQ-015 SHALL have port busy  output  1  high from start acceptance until frame_done.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last write.
REQ-017 SHALL have port overflow  output  1  sticky flag: some sum exceeded SUM_W bits this frame.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-019 SHALL move IDLE->RUN on start; clear x/y counters, row accumulator, overflow; set busy.
REQ-020 SHALL assert pix_ready only in RUN; a pixel is accepted when pix_valid and pix_ready are both high.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL keep a line buffer of IMG_WIDTH SUM_W words holding integral values of the previous row; row 0 reads it as zero.
REQ-023 SHALL, per accepted pixel p at (x,y): rowsum = (x==0 ? 0 : rowsum) + p; ii = linebuf[x] (0 if y==0) + rowsum; linebuf[x] <= ii.
REQ-024 SHALL perform all additions modulo 2^SUM_W, with pixels zero-extended.
REQ-025 SHALL set overflow when any addition carries out of SUM_W bits; it stays set until the next start or reset.
REQ-026 SHALL register the write: ii_we, ii_x, ii_y, ii_wdata valid exactly one cycle after pixel acceptance.
REQ-027 SHALL deassert ii_we in every cycle without a preceding acceptance; gaps in pix_valid stall with no writes.
REQ-028 SHALL advance x each acceptance, wrapping to 0 with y+1 at x==IMG_WIDTH-1.
REQ-029 SHALL move RUN->FLUSH on accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1); pix_ready is 0 in FLUSH.
REQ-030 SHALL move FLUSH->DONE after the last write cycle, and DONE->IDLE after one cycle with frame_done=1, busy=0.
REQ-031 SHALL not change ii_x, ii_y, ii_wdata while ii_we is low, except at reset.
REQ-032 SHALL sustain one pixel per cycle with pix_valid held high: IMG_WIDTH*IMG_HEIGHT consecutive writes.

Reset
REQ-033 SHALL, while reset is low, force state IDLE, pix_ready=0, ii_we=0, ii_x=0, ii_y=0, ii_wdata=0, busy=0, frame_done=0, overflow=0, counters and row accumulator 0.
REQ-034 SHALL abandon any in-progress frame on reset assertion; a write registered in that cycle is not issued.
REQ-035 SHALL leave line-buffer contents unspecified after reset; they are never read before being written in row 0.

Verification
REQ-036 SHALL pass: start, 400 pixels of value 1 back-to-back -> 400 writes, ii(x,y)=(x+1)(y+1), ii(19,19)=400, overflow=0, frame_done one cycle after final write.
REQ-037 SHALL pass: pixel value = x+y -> every write equals a software integral-image model; ii(0,0)=0, ii(1,0)=1, ii(1,1)=4.
REQ-038 SHALL pass: all pixels 255 -> ii(19,19)=102000 mod 65536=36464, overflow=1 after first carry, held to frame end.
REQ-039 SHALL pass: pix_valid random ~50% duty -> write sequence identical to REQ-036, no writes in gap cycles.
REQ-040 SHALL pass: reset low mid-row 5, then new start with all-ones frame -> outputs all reset values during reset, second frame matches REQ-036 exactly.
REQ-041 SHALL pass: start pulsed again during RUN -> ignored, counters continue, single frame_done.
